gpu_fetch_unit: RTL and testbench

GPU_FETCH_UNIT -- requirements
Module: gpu_fetch_unit

---
 rtl/gpu_fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_gpu_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_fetch_unit.sv
// Instruction fetch unit: sequential fetch from a 1-cycle-latency memory into a small FIFO, stops on a zero (HALT) word.
// Optional GPU_FETCH_PERF_CNT_EN adds a saturating stall_cycles counter output.
module gpu_fetch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PC_WIDTH-1:0]    start_pc,
  output logic                   imem_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   busy,
  output logic                   done
`ifdef GPU_FETCH_PERF_CNT_EN
  ,
  output logic [15:0]            stall_cycles
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_O = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic                inflight_q, inflight_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;

  logic [INSTR_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    pc_mem    [FIFO_DEPTH];

  logic          pop, pop_en, push, issue, flush, start_acc, rsp_halt;
  logic [CW:0]   occ;
  logic [CW-1:0] cnt_after_pop;

  always_comb begin
    pop           = (count_q != '0) && out_ready;
    rsp_halt      = inflight_q && (imem_rdata == '0);
    start_acc     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    // Entries leaving this cycle free a slot, so a draining decode keeps one fetch per cycle.
    occ           = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    cnt_after_pop = count_q - CW'(pop);

    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pop_en     = 1'b0;
    push       = 1'b0;
    issue      = 1'b0;
    flush      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          state_d = S_FETCH;
          pc_d    = start_pc;
          flush   = 1'b1;
        end
      end
      S_FETCH: begin
        if (redirect_valid) begin
          state_d = S_FETCH;
          pc_d    = redirect_pc;
          flush   = 1'b1;
        end else begin
          push   = inflight_q && !rsp_halt;
          pop_en = pop;
          if (!rsp_halt && (occ < DEPTH_O)) begin
            issue    = 1'b1;
            pc_d     = pc_q + PC_WIDTH'(1);
            rsp_pc_d = pc_q;
          end
          inflight_d = issue;
          if (rsp_halt) begin
            state_d = (cnt_after_pop == '0) ? S_DONE : S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          state_d = S_FETCH;
          pc_d    = redirect_pc;
          flush   = 1'b1;
        end else begin
          pop_en = pop;
          if (cnt_after_pop == '0) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      rsp_pc_q   <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: the head is only exposed while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= rsp_pc_q;
    end
  end

  assign imem_en   = issue;
  assign imem_addr = pc_q;
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_q] : '0;
  assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

`ifdef GPU_FETCH_PERF_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_gpu_fetch_unit.sv
// Bench for gpu_fetch_unit: directed scenarios plus randomized runs against a program-walk reference model.
module tb_gpu_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  start_pc;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        busy;
  logic        done;
`ifdef GPU_FETCH_PERF_CNT_EN
  logic [15:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  gpu_fetch_unit dut (
    .clk(clk), .reset(rst), .start(start), .start_pc(start_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .done(done)
`ifdef GPU_FETCH_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  logic [31:0] mem [256];

  // Synchronous-read instruction memory; data outside a response cycle is junk.
  always @(posedge clk) imem_rdata <= imem_en ? mem[imem_addr] : $urandom;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
  } item_t;

  int    checks = 0;
  int    errors = 0;
  item_t exp_q[$];
  item_t got_q[$];
  bit    model_busy = 1'b0;
  bit    prev_hold  = 1'b0;
  logic [31:0] prev_instr;
  logic [7:0]  prev_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: the delivered stream is the memory walked from pc until the first zero word.
  function automatic void build(input logic [7:0] pc0);
    logic [7:0] p;
    p = pc0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      if (mem[p] == 32'd0) break;
      exp_q.push_back('{pc: p, instr: mem[p]});
      p = p + 8'd1;
    end
  endfunction

  always @(negedge clk) begin
    item_t e;
    if (rst) begin
      exp_q.delete();
      model_busy = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_instr", 64'(out_instr), 64'(prev_instr));
        chk("hold_pc", 64'(out_pc), 64'(prev_pc));
      end
      prev_hold = 1'b0;
      if (done) begin
        chk("done_quiet", 64'({imem_en, out_valid, busy}), 64'd0);
        chk("done_model_empty", 64'(exp_q.size()), 64'd0);
      end
      if (start && (!model_busy || done)) begin
        build(start_pc);
        model_busy = 1'b1;
      end else if (model_busy && !done) begin
        chk("busy", 64'(busy), 64'd1);
        if (redirect_valid) begin
          build(redirect_pc);
        end else if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_unexpected actual=pc %0h instr %0h required=no transfer", out_pc, out_instr);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_pc", 64'(out_pc), 64'(e.pc));
            chk("xfer_instr", 64'(out_instr), 64'(e.instr));
          end
          got_q.push_back('{pc: out_pc, instr: out_instr});
        end else if (out_valid && !out_ready) begin
          prev_hold  = 1'b1;
          prev_instr = out_instr;
          prev_pc    = out_pc;
        end
      end else if (!model_busy) begin
        chk("idle_quiet", 64'({busy, out_valid, imem_en, done}), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] pc);
    start_pc = pc;
    start    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; start_pc = '0; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'd1;
    #1;
    chk("reset_outputs", 64'({imem_en, out_valid, busy, done}), 64'd0);
    chk("reset_out_data", 64'({out_instr, out_pc}), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Basic program, decode always ready.
    mem[0] = 32'h0312; mem[1] = 32'h1412; mem[2] = 32'h2522; mem[3] = 32'h0;
    out_ready = 1'b1;
    pulse_start(8'd0);
    @(negedge clk);
    chk("t1_first_issue", 64'({imem_en, imem_addr, out_valid}), 64'({1'b1, 8'd0, 1'b0}));
    @(negedge clk);
    chk("t1_valid_lat1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("t1_xfer0", 64'({out_valid, out_pc, out_instr}), 64'({1'b1, 8'd0, 32'h0312}));
    @(negedge clk);
    chk("t1_xfer1", 64'({out_valid, out_pc, out_instr}), 64'({1'b1, 8'd1, 32'h1412}));
    @(negedge clk);
    chk("t1_xfer2", 64'({out_valid, out_pc, out_instr}), 64'({1'b1, 8'd2, 32'h2522}));
    @(negedge clk);
    chk("t1_done", 64'({done, out_valid}), 64'({1'b1, 1'b0}));
    tick();

    // Backpressure: FIFO fills to two entries and fetch stalls.
    out_ready = 1'b0;
    base = got_q.size();
    pulse_start(8'd0);
    repeat (3) @(negedge clk);
    chk("t2_first_valid", 64'(out_valid), 64'd1);
    repeat (4) @(negedge clk);
    chk("t2_full_stall", 64'({imem_en, out_valid, out_instr, out_pc}), 64'({1'b0, 1'b1, 32'h0312, 8'd0}));
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
`ifdef GPU_FETCH_PERF_CNT_EN
    @(negedge clk);
    chk("t2_stall_cycles", 64'(stall_cycles), 64'd7);
`endif
    wait_done(50);
    chk("t2_count", 64'(got_q.size() - base), 64'd3);
    if (got_q.size() >= base + 3) begin
      chk("t2_order0", 64'(got_q[base].instr), 64'h0312);
      chk("t2_order1", 64'(got_q[base+1].instr), 64'h1412);
      chk("t2_order2", 64'(got_q[base+2].instr), 64'h2522);
    end

    // PC wrap from 255 to 0.
    mem[255] = 32'h4721; mem[0] = 32'h5821; mem[1] = 32'h0;
    base = got_q.size();
    pulse_start(8'd255);
    wait_done(50);
    chk("t3_count", 64'(got_q.size() - base), 64'd2);
    if (got_q.size() >= base + 2) begin
      chk("t3_wrap0", 64'({got_q[base].pc, got_q[base].instr}), 64'({8'd255, 32'h4721}));
      chk("t3_wrap1", 64'({got_q[base+1].pc, got_q[base+1].instr}), 64'({8'd0, 32'h5821}));
    end

    // Redirect while two entries are buffered; the same-cycle pop must not count.
    for (int i = 0; i < 20; i++) mem[i] = 32'h100 + 32'(i);
    mem[20] = 32'h0;
    out_ready = 1'b0;
    pulse_start(8'd0);
    repeat (4) tick();
    chk("t4_buffered", 64'(out_valid), 64'd1);
    base = got_q.size();
    redirect_valid = 1'b1; redirect_pc = 8'd10; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_flushed", 64'(out_valid), 64'd0);
    wait_done(100);
    chk("t4_count", 64'(got_q.size() - base), 64'd10);
    if (got_q.size() > base) begin
      chk("t4_first_pc", 64'({got_q[base].pc, got_q[base].instr}), 64'({8'd10, 32'h10A}));
    end

    // Asynchronous reset mid-stream.
    pulse_start(8'd0);
    repeat (3) tick();
    #3 rst = 1'b1;
    #1;
    chk("t5_async_ctrl", 64'({imem_en, out_valid, busy, done}), 64'd0);
    chk("t5_async_data", 64'({out_instr, out_pc}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    base = got_q.size();
    repeat (5) begin
      @(negedge clk);
      chk("t5_quiet", 64'({imem_en, out_valid}), 64'd0);
    end
    chk("t5_no_xfer", 64'(got_q.size() - base), 64'd0);
    tick();

    // Randomized programs, backpressure, redirects and ignored starts.
    for (int r = 0; r < 40; r++) begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom | 32'd1);
      mem[$urandom_range(0, 255)] = 32'd0;
      out_ready = 1'b1;
      pulse_start(8'($urandom));
      n = 0;
      while (!done && n < 3000) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (exp_q.size() > 1 && $urandom_range(0, 39) == 0) begin
          redirect_valid = 1'b1;
          redirect_pc    = 8'($urandom);
        end else if (exp_q.size() > 0 && $urandom_range(0, 49) == 0) begin
          start    = 1'b1;
          start_pc = 8'($urandom);
        end
        tick();
        redirect_valid = 1'b0;
        start = 1'b0;
        n++;
      end
      chk("rand_done", 64'(done), 64'd1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
